tone_player: RTL and testbench

- Parametrised square-wave note player that drives a single-bit loudspeaker output.
- Successor to the free-running note-to-tone converter. Adds a valid/ready note interface, per-note duration, rests, an articulation gap, octave transposition and a completion pulse.
- Sits between the game/menu sound sequencer and the speaker pin.

---
 rtl/tone_pkg.sv | 32 +++
 rtl/tone_player_if.sv | 22 ++
 rtl/tone_tick_gen.sv | 29 ++
 rtl/tone_player.sv | 133 +++++++++++++
 tb/tb_tone_player.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tone_pkg.sv
// Shared definitions for the tone player: note half-period table, lookup helper
// and FSM state type.
package tone_pkg;

  localparam int unsigned NOTE_TABLE_N = 32;

  localparam logic [31:0] NOTE_TABLE [NOTE_TABLE_N] = '{
    32'd50000,  32'd53000,  32'd56000,  32'd60000,
    32'd63000,  32'd67000,  32'd70000,  32'd75000,
    32'd80000,  32'd85000,  32'd90000,  32'd95000,
    32'd100000, 32'd107000, 32'd113000, 32'd120000,
    32'd127000, 32'd135000, 32'd143000, 32'd150000,
    32'd160000, 32'd170000, 32'd180000, 32'd192000,
    32'd203000, 32'd215000, 32'd227000, 32'd240000,
    32'd254000, 32'd270000, 32'd286000, 32'd290000
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAY,
    ST_GAP
  } tone_state_e;

  // Unshifted half-period in clk cycles; codes outside the table are silence.
  function automatic logic [31:0] note_half(input logic [31:0] code);
    if (code < 32'(NOTE_TABLE_N))
      return NOTE_TABLE[code[4:0]];
    else
      return '0;
  endfunction

endpackage

// File: rtl/tone_player_if.sv
// Note request channel (valid/ready plus note fields) between the sound
// sequencer (master) and the tone player (slave).
interface tone_player_if #(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned DUR_W  = 16
);
  logic              note_valid;
  logic              note_ready;
  logic [NOTE_W-1:0] note_code;
  logic [DUR_W-1:0]  note_dur;
  logic              note_rest;

  modport master (
    output note_valid, note_code, note_dur, note_rest,
    input  note_ready
  );

  modport slave (
    input  note_valid, note_code, note_dur, note_rest,
    output note_ready
  );
endinterface

// File: rtl/tone_tick_gen.sv
// Duration prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
// Synchronous clear restarts the count at 0.
module tone_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + TW'(1);
  end

  // Not gated by clr: the FSM derives clr from tick, so gating would loop.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/tone_player.sv
// Square-wave note player with valid/ready note input, duration, rests,
// articulation gap and done pulse. Define TONE_PLAYER_ABORT_EN to add abort.
module tone_player
  import tone_pkg::*;
#(
  parameter int unsigned CNT_W     = 18,
  parameter int unsigned NOTE_W    = 5,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned GAP_TICKS = 10,
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic          clk,
  input  logic          rst,
  tone_player_if.slave  note,
`ifdef TONE_PLAYER_ABORT_EN
  input  logic          abort,
`endif
  output logic          audio,
  output logic          busy,
  output logic          note_done
);

  localparam int unsigned GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  tone_state_e       state, state_n;
  logic [CNT_W-1:0]  half_r, half_cnt, half_new;
  logic [DUR_W-1:0]  dur_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [NOTE_W-1:0] code_s;
  logic              tick, tick_clr;
  logic              load, play_end, abort_hit, done_c;

  tone_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (tick)
  );

  assign code_s   = note.note_code;
  // Shift on the full-width table value, then truncate to the counter width.
  assign half_new = note.note_rest ? '0
                  : CNT_W'(note_half(32'(code_s)) >> DIV_SHIFT);

  assign note.note_ready = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n   = state;
    load      = 1'b0;
    play_end  = 1'b0;
    abort_hit = 1'b0;
`ifdef TONE_PLAYER_ABORT_EN
    abort_hit = abort && (state != ST_IDLE);
`endif
    unique case (state)
      ST_IDLE: begin
        if (note.note_valid) begin
          load    = 1'b1;
          state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // dur_cnt can only be 0 here if the note was accepted with dur=0.
        if (dur_cnt == '0 || (tick && dur_cnt == DUR_W'(1))) begin
          play_end = 1'b1;
          state_n  = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick && gap_cnt == GAP_W'(1))
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_hit) begin
      play_end = 1'b0;
      state_n  = ST_IDLE;
    end
  end

  assign done_c   = play_end || abort_hit;
  assign tick_clr = (state == ST_IDLE) || done_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      audio     <= 1'b0;
      note_done <= 1'b0;
      half_r    <= '0;
      half_cnt  <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
    end else begin
      note_done <= done_c;

      if (load) begin
        half_r   <= half_new;
        half_cnt <= half_new;
        dur_cnt  <= note.note_dur;
        audio    <= 1'b0;
      end else if (state == ST_PLAY && !done_c) begin
        if (tick)
          dur_cnt <= dur_cnt - DUR_W'(1);
        if (half_r == '0) begin
          audio <= 1'b0;
        end else if (half_cnt > CNT_W'(1)) begin
          half_cnt <= half_cnt - CNT_W'(1);
        end else begin
          half_cnt <= half_r;
          audio    <= ~audio;
        end
      end else begin
        audio <= 1'b0;
      end

      if (play_end)
        gap_cnt <= GAP_W'(GAP_TICKS);
      else if (state == ST_GAP && tick)
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player with TICK_DIV=8, GAP_TICKS=1, DIV_SHIFT=10.
module tb_tone_player;

  localparam int unsigned TICK  = 8;
  localparam int unsigned GAPT  = 1;
  localparam int unsigned SHIFT = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic audio, busy, note_done;
`ifdef TONE_PLAYER_ABORT_EN
  logic abort = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  int unsigned tbl [32] = '{
    50000, 53000, 56000, 60000, 63000, 67000, 70000, 75000,
    80000, 85000, 90000, 95000, 100000, 107000, 113000, 120000,
    127000, 135000, 143000, 150000, 160000, 170000, 180000, 192000,
    203000, 215000, 227000, 240000, 254000, 270000, 286000, 290000
  };

  tone_player_if #(.NOTE_W(5), .DUR_W(16)) nif ();

  tone_player #(
    .CNT_W     (18),
    .NOTE_W    (5),
    .DUR_W     (16),
    .TICK_DIV  (TICK),
    .GAP_TICKS (GAPT),
    .DIV_SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .note      (nif),
`ifdef TONE_PLAYER_ABORT_EN
    .abort     (abort),
`endif
    .audio     (audio),
    .busy      (busy),
    .note_done (note_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] observed();
    return {audio, note_done, nif.note_ready, busy};
  endfunction

  // Drive a note in IDLE; returns at the first PLAY cycle (c=0).
  task automatic accept_note(input int code, input int dur, input bit rest);
    nif.note_valid = 1'b1;
    nif.note_code  = 5'(code);
    nif.note_dur   = 16'(dur);
    nif.note_rest  = rest;
    @(negedge clk);
  endtask

  // Check every cycle of a note from PLAY entry to the first IDLE cycle.
  // At c=0 the inputs switch to the next note (held valid) or to noise.
  task automatic check_note(input int code, input int dur, input bit rest,
                            input string tag, input bit nv,
                            input int ncode, input int ndur, input bit nrest);
    int L, h, last;
    logic [3:0] exp_v, act;
    L    = (dur == 0) ? 1 : dur * TICK;
    h    = rest ? 0 : int'(tbl[code] >> SHIFT);
    last = L + GAPT * TICK;
    for (int c = 0; c <= last; c++) begin
      if (c == 0) begin
        nif.note_valid = nv;
        nif.note_code  = nv ? 5'(ncode) : 5'($urandom);
        nif.note_dur   = nv ? 16'(ndur) : 16'($urandom);
        nif.note_rest  = nv ? nrest : 1'($urandom);
      end
      exp_v[3] = (c < L) && (h != 0) && (((c / h) % 2) == 1);
      exp_v[2] = (c == L);
      exp_v[0] = (c < last);
      exp_v[1] = !exp_v[0];
      act = observed();
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL %s c=%0d {audio,done,ready,busy} got %b expected %b",
                 tag, c, act, exp_v);
      end
      if (c < last) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    nif.note_valid = 1'b0;
    nif.note_code  = '0;
    nif.note_dur   = '0;
    nif.note_rest  = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (observed() !== 4'b0010) begin
      fails++;
      $display("FAIL reset_hold got %b expected 0010", observed());
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (observed() !== 4'b0010) begin
      fails++;
      $display("FAIL reset_release got %b expected 0010", observed());
    end
  endtask

  task automatic test_tone();
    accept_note(0, 20, 1'b0);
    check_note(0, 20, 1'b0, "tone", 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_rest();
    accept_note(5, 2, 1'b1);
    check_note(5, 2, 1'b1, "rest", 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_dur_zero();
    accept_note(7, 0, 1'b0);
    check_note(7, 0, 1'b0, "dur0", 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    accept_note(3, 4, 1'b0);
    check_note(3, 4, 1'b0, "b2b_first", 1'b1, 9, 3, 1'b0);
    @(negedge clk);
    check_note(9, 3, 1'b0, "b2b_second", 1'b0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int code, dur;
    bit rest;
    for (int n = 0; n < 20; n++) begin
      code = int'($urandom_range(0, 31));
      dur  = int'($urandom_range(0, 12));
      rest = ($urandom_range(0, 3) == 0);
      accept_note(code, dur, rest);
      check_note(code, dur, rest, "random", 1'b0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid_note();
    accept_note(0, 20, 1'b0);
    nif.note_valid = 1'b0;
    repeat (60) @(negedge clk);
    tests++;
    if (observed() !== 4'b1001) begin
      fails++;
      $display("FAIL midrst_before got %b expected 1001", observed());
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if (observed() !== 4'b0010) begin
      fails++;
      $display("FAIL midrst_async got %b expected 0010", observed());
    end
    @(negedge clk);
    tests++;
    if (observed() !== 4'b0010) begin
      fails++;
      $display("FAIL midrst_hold got %b expected 0010", observed());
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (observed() !== 4'b0010) begin
      fails++;
      $display("FAIL midrst_release got %b expected 0010", observed());
    end
  endtask

`ifdef TONE_PLAYER_ABORT_EN
  task automatic test_abort();
    accept_note(0, 20, 1'b0);
    nif.note_valid = 1'b0;
    repeat (30) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    tests++;
    if (observed() !== 4'b0110) begin
      fails++;
      $display("FAIL abort_done got %b expected 0110", observed());
    end
    // abort together with a request in IDLE: the note is still accepted
    accept_note(2, 1, 1'b0);
    abort = 1'b0;
    check_note(2, 1, 1'b0, "abort_idle_accept", 1'b0, 0, 0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_tone();
    test_rest();
    test_dur_zero();
    test_back_to_back();
    test_random();
    test_reset_mid_note();
`ifdef TONE_PLAYER_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
